// File: rtl/exec_pkg.sv
// Shared types and encodings for the execute-stage ALU/MDU unit.
package exec_pkg;

  localparam logic [1:0] ALUOP_ITYPE  = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  localparam logic [9:0] F_AND  = 10'b0000000_111;
  localparam logic [9:0] F_XOR  = 10'b0000000_100;
  localparam logic [9:0] F_SLL  = 10'b0000000_001;
  localparam logic [9:0] F_ADD  = 10'b0000000_000;
  localparam logic [9:0] F_SUB  = 10'b0100000_000;
  localparam logic [9:0] F_MUL  = 10'b0000001_000;
  localparam logic [9:0] F_MULH = 10'b0000001_001;
  localparam logic [9:0] F_DIV  = 10'b0000001_100;
  localparam logic [9:0] F_REM  = 10'b0000001_110;
  localparam logic [9:0] F_SRAI = 10'b0100000_101;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LDST = 3'b010;

  typedef enum logic [3:0] {
    OP_AND, OP_XOR, OP_SLL, OP_ADD, OP_SUB, OP_SRAI,
    OP_MUL, OP_MULH, OP_DIV, OP_REM, OP_ILL
  } op_t;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of {funct7,funct3} and ALUOp into an operation.
module alu_op_decode
  import exec_pkg::*;
(
  input  logic [9:0] funct,
  input  logic [1:0] alu_op,
  output op_t        op_c,
  output logic       illegal_c
);

  always_comb begin
    op_c = OP_ILL;
    case (alu_op)
      ALUOP_RTYPE: begin
        case (funct)
          F_AND:   op_c = OP_AND;
          F_XOR:   op_c = OP_XOR;
          F_SLL:   op_c = OP_SLL;
          F_ADD:   op_c = OP_ADD;
          F_SUB:   op_c = OP_SUB;
          F_MUL:   op_c = OP_MUL;
          F_MULH:  op_c = OP_MULH;
          F_DIV:   op_c = OP_DIV;
          F_REM:   op_c = OP_REM;
          default: op_c = OP_ILL;
        endcase
      end
      // funct7 carries immediate bits here, so only srai checks it
      ALUOP_ITYPE: begin
        if (funct == F_SRAI)
          op_c = OP_SRAI;
        else if (funct[2:0] == F3_ADDI || funct[2:0] == F3_LDST)
          op_c = OP_ADD;
        else
          op_c = OP_ILL;
      end
      ALUOP_BRANCH: op_c = OP_SUB;
      ALUOP_RSVD:   op_c = OP_ILL;
      default:      op_c = OP_ILL;
    endcase
  end

  assign illegal_c = (op_c == OP_ILL);

endmodule

// File: rtl/alu_mdu_ctrl.sv
// Execute-stage unit: single-cycle ALU ops plus an iterative 1-bit/cycle
// signed multiplier/divider behind a valid/ready handshake.
module alu_mdu_ctrl
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [9:0]      funct_i,
  input  logic [1:0]      ALUOp_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  op_t             dec_op;
  logic            dec_ill;
  state_t          state_q;
  op_t             op_q;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, dvs_q;
  logic            neg_q, rneg_q;

  logic            accept_c, go_multi_c, div_zero_c, div_ovf_c;
  logic            a_neg_c, b_neg_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c, single_res_c, fix_res_c;
  logic [XLEN-1:0] hi_nxt_c, lo_nxt_c, div_diff_c;
  logic [XLEN:0]   mul_sum_c, div_shift_c;
  logic            div_ge_c;
  logic [2*XLEN-1:0] prod_c, prod_s_c;

  alu_op_decode u_dec (
    .funct     (funct_i),
    .alu_op    (ALUOp_i),
    .op_c      (dec_op),
    .illegal_c (dec_ill)
  );

  assign ready_o  = (state_q == IDLE) & ~rst_i;
  assign accept_c = valid_i & ready_o & ~flush_i;

  assign a_neg_c    = op_a_i[XLEN-1];
  assign b_neg_c    = op_b_i[XLEN-1];
  assign a_mag_c    = a_neg_c ? -op_a_i : op_a_i;
  assign b_mag_c    = b_neg_c ? -op_b_i : op_b_i;
  assign div_zero_c = (op_b_i == '0);
  assign div_ovf_c  = (op_a_i == MIN_NEG) && (op_b_i == '1);
  assign go_multi_c = (dec_op == OP_MUL) || (dec_op == OP_MULH) ||
                      ((dec_op == OP_DIV || dec_op == OP_REM) && !div_zero_c && !div_ovf_c);

  // Single-cycle results, including the two division shortcuts
  always_comb begin
    single_res_c = '0;
    case (dec_op)
      OP_AND:  single_res_c = op_a_i & op_b_i;
      OP_XOR:  single_res_c = op_a_i ^ op_b_i;
      OP_SLL:  single_res_c = op_a_i << op_b_i[SHW-1:0];
      OP_ADD:  single_res_c = op_a_i + op_b_i;
      OP_SUB:  single_res_c = op_a_i - op_b_i;
      OP_SRAI: single_res_c = $unsigned($signed(op_a_i) >>> op_b_i[SHW-1:0]);
      OP_DIV:  single_res_c = div_zero_c ? '1 : op_a_i;
      OP_REM:  single_res_c = div_zero_c ? op_a_i : '0;
      default: single_res_c = '0;
    endcase
  end

  // One iteration: shift-add multiply on {hi,lo}, or restoring divide
  always_comb begin
    mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    div_shift_c = {hi_q, lo_q[XLEN-1]};
    div_ge_c    = (div_shift_c >= {1'b0, dvs_q});
    div_diff_c  = div_shift_c[XLEN-1:0] - dvs_q;
    hi_nxt_c    = '0;
    lo_nxt_c    = '0;
    if (op_q == OP_MUL || op_q == OP_MULH) begin
      hi_nxt_c = mul_sum_c[XLEN:1];
      lo_nxt_c = {mul_sum_c[0], lo_q[XLEN-1:1]};
    end else begin
      hi_nxt_c = div_ge_c ? div_diff_c : div_shift_c[XLEN-1:0];
      lo_nxt_c = {lo_q[XLEN-2:0], div_ge_c};
    end
  end

  // Sign correction of the magnitude result
  always_comb begin
    prod_c    = {hi_q, lo_q};
    prod_s_c  = neg_q ? -prod_c : prod_c;
    fix_res_c = '0;
    case (op_q)
      OP_MUL:  fix_res_c = prod_s_c[XLEN-1:0];
      OP_MULH: fix_res_c = prod_s_c[2*XLEN-1:XLEN];
      OP_DIV:  fix_res_c = neg_q ? -lo_q : lo_q;
      OP_REM:  fix_res_c = rneg_q ? -hi_q : hi_q;
      default: fix_res_c = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      zero_o      <= 1'b1;
      illegal_o   <= 1'b0;
      cnt_q       <= '0;
      op_q        <= OP_ILL;
      hi_q        <= '0;
      lo_q        <= '0;
      dvs_q       <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
    end else begin
      out_valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            if (go_multi_c) begin
              state_q <= ITER;
              cnt_q   <= '0;
              op_q    <= dec_op;
              hi_q    <= '0;
              lo_q    <= a_mag_c;
              dvs_q   <= b_mag_c;
              neg_q   <= a_neg_c ^ b_neg_c;
              rneg_q  <= a_neg_c;
            end else begin
              out_valid_o <= 1'b1;
              result_o    <= single_res_c;
              zero_o      <= (single_res_c == '0);
              illegal_o   <= dec_ill;
            end
          end
        end
        ITER: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            hi_q  <= hi_nxt_c;
            lo_q  <= lo_nxt_c;
            cnt_q <= cnt_q + SHW'(1);
            if (cnt_q == SHW'(XLEN - 1)) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          if (!flush_i) begin
            out_valid_o <= 1'b1;
            result_o    <= fix_res_c;
            zero_o      <= (fix_res_c == '0);
            illegal_o   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
